// File: rtl/mm_buf_pkg.sv
// Shared definitions for the matrix-multiply result reorder buffer.
// Contents: write-mode constants, buffer state encoding, and the address
// width helper used to size pointers from DEPTH.
package mm_buf_pkg;

  localparam logic MODE_LINEAR  = 1'b0;
  localparam logic MODE_STRIDED = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } buf_state_e;

  // Address width for a DEPTH-entry RAM; never below 1 bit.
  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mm_rd_downsizer.sv
// Splits IN_W-wide RAM words into OUT_W-wide beats, lowest slice first.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        drop every held word and beat position (new tile)
//   in_valid     word from the RAM output register is present this cycle
//   in_ready     a word can be taken (skid slot free)
//   in_data      IN_W word
//   pend         a word is in flight in the RAM read stage
//   room         issuing a RAM read this cycle is guaranteed to find space
//   out_valid    out_data holds a valid beat
//   out_ready    consumer takes the beat
//   out_data     OUT_W beat
//   word_done    last beat of the current word is taken this cycle
module mm_rd_downsizer #(
  parameter int IN_W  = 2048,
  parameter int OUT_W = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             pend,
  output logic             room,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             word_done
);

  localparam int R  = IN_W / OUT_W;
  localparam int BW = (R > 1) ? $clog2(R) : 1;

  logic [IN_W-1:0] cur_q, cur_d, skid_q, skid_d;
  logic            cur_v_q, cur_v_d, skid_v_q, skid_v_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            last_beat, fire, leaving, in_fire;
  logic [1:0]      held;

  always_comb begin
    last_beat = (beat_q == BW'(R - 1));
    fire      = cur_v_q && out_ready;
    leaving   = fire && last_beat;
    in_ready  = !skid_v_q;
    in_fire   = in_valid && in_ready;
    // Words that will occupy cur/skid next cycle; a read issued now lands
    // one cycle later, so it is safe only if fewer than two slots are taken.
    held      = 2'(cur_v_q) + 2'(skid_v_q) + 2'(pend);
    room      = (held - 2'(leaving)) < 2'd2;

    cur_d    = cur_q;
    cur_v_d  = cur_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    beat_d   = beat_q;

    if (fire) beat_d = last_beat ? '0 : beat_q + 1'b1;

    // skid is only ever occupied while cur is, so it refills cur first.
    if (!cur_v_q || leaving) begin
      if (skid_v_q) begin
        cur_d    = skid_q;
        cur_v_d  = 1'b1;
        skid_v_d = 1'b0;
      end else if (in_fire) begin
        cur_d   = in_data;
        cur_v_d = 1'b1;
      end else begin
        cur_v_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d   = in_data;
      skid_v_d = 1'b1;
    end

    if (flush) begin
      cur_v_d  = 1'b0;
      skid_v_d = 1'b0;
      beat_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q    <= '0;
      cur_v_q  <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      beat_q   <= '0;
    end else begin
      cur_q    <= cur_d;
      cur_v_q  <= cur_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      beat_q   <= beat_d;
    end
  end

  assign out_valid = cur_v_q;
  assign out_data  = cur_q[int'(beat_q) * OUT_W +: OUT_W];
  assign word_done = leaving;

endmodule

// File: rtl/mm_result_reorder_buffer.sv
// Result-side reorder buffer of the matrix-multiply AFU. Result words are
// written linearly or column-strided into a DEPTH x IN_W RAM and streamed
// out in ascending address order as OUT_W beats.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 pulse: latch cfg_*, clear pointers, begin a tile
//   cfg_mode              0 linear, 1 strided
//   cfg_rows, cfg_stride  tile geometry (0 is treated as 1)
//   wr_valid/wr_ready/wr_data   write side
//   rd_valid/rd_ready/rd_data   read side
//   tile_done             pulse after the last beat of a tile is taken
//   overflow              sticky: requested tile exceeds DEPTH
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. valid never waits for ready, and once rd_valid is high rd_data
// and rd_valid hold until the beat is taken (only start or reset drop them).
module mm_result_reorder_buffer
  import mm_buf_pkg::*;
#(
  parameter int IN_W  = 2048,
  parameter int OUT_W = 1024,
  parameter int DEPTH = 512,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cfg_mode,
  input  logic [CNT_W-1:0] cfg_rows,
  input  logic [CNT_W-1:0] cfg_stride,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [IN_W-1:0]  wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [OUT_W-1:0] rd_data,
  output logic             tile_done,
  output logic             overflow
);

  localparam int AW = calc_aw(DEPTH);
  localparam int NW = 2 * CNT_W;

  buf_state_e       state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] rows_q, rows_d, stride_q, stride_d;
  logic [AW:0]      n_q, n_d;
  logic [AW:0]      wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0] row_idx_q, row_idx_d;
  logic [AW-1:0]    col_base_q, col_base_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      done_cnt_q, done_cnt_d;
  logic             ram_valid_q, ram_valid_d;
  logic             overflow_q, overflow_d;
  logic             tile_done_q, tile_done_d;
  logic             wr_ready_q, wr_ready_d;

  logic [CNT_W-1:0] rows_eff, stride_eff;
  logic [NW-1:0]    n_full;
  logic             too_big, wr_fire, readable, rd_en;
  logic [AW-1:0]    wr_addr;
  logic [AW:0]      rd_limit;

  logic [IN_W-1:0]  mem [DEPTH];
  logic [IN_W-1:0]  ram_rd_data_q;

  logic             ds_room, ds_in_ready, ds_word_done;

  always_comb begin
    rows_eff   = (cfg_rows == '0) ? CNT_W'(1) : cfg_rows;
    stride_eff = (cfg_stride == '0) ? CNT_W'(1) : cfg_stride;
    n_full     = (cfg_mode == MODE_LINEAR) ? NW'(rows_eff)
                                           : NW'(rows_eff) * NW'(stride_eff);
    too_big    = n_full > NW'(DEPTH);

    wr_fire = wr_valid && wr_ready_q;
    wr_addr = (mode_q == MODE_LINEAR) ? wr_cnt_q[AW-1:0] : addr_q;

    // Linear tiles stream out behind the writer; strided tiles must be
    // complete first because address order differs from write order.
    if (mode_q == MODE_LINEAR) rd_limit = wr_cnt_q;
    else                       rd_limit = (state_q == ST_DRAIN) ? n_q : '0;
    readable = (state_q != ST_IDLE) && (rd_ptr_q < rd_limit);
    rd_en    = readable && ds_room && ds_in_ready && !start;

    state_d     = state_q;
    mode_d      = mode_q;
    rows_d      = rows_q;
    stride_d    = stride_q;
    n_d         = n_q;
    overflow_d  = overflow_q;
    wr_cnt_d    = wr_cnt_q;
    addr_d      = addr_q;
    row_idx_d   = row_idx_q;
    col_base_d  = col_base_q;
    rd_ptr_d    = rd_ptr_q;
    done_cnt_d  = done_cnt_q;
    ram_valid_d = 1'b0;
    tile_done_d = 1'b0;

    if (start) begin
      mode_d     = cfg_mode;
      rows_d     = rows_eff;
      stride_d   = stride_eff;
      wr_cnt_d   = '0;
      addr_d     = '0;
      row_idx_d  = '0;
      col_base_d = '0;
      rd_ptr_d   = '0;
      done_cnt_d = '0;
      if (too_big) begin
        overflow_d = 1'b1;
        state_d    = ST_IDLE;
      end else begin
        overflow_d = 1'b0;
        n_d        = n_full[AW:0];
        state_d    = ST_FILL;
      end
    end else begin
      if (wr_fire) begin
        wr_cnt_d = wr_cnt_q + 1'b1;
        // Walk down a column by stride; at the column end jump back to the
        // top of the next column.
        if (row_idx_q == rows_q - 1'b1) begin
          row_idx_d  = '0;
          col_base_d = col_base_q + 1'b1;
          addr_d     = col_base_q + 1'b1;
        end else begin
          row_idx_d = row_idx_q + 1'b1;
          addr_d    = addr_q + AW'(stride_q);
        end
        if (wr_cnt_q + 1'b1 == n_q) state_d = ST_DRAIN;
      end
      if (rd_en) begin
        rd_ptr_d    = rd_ptr_q + 1'b1;
        ram_valid_d = 1'b1;
      end
      if (ds_word_done && (state_q != ST_IDLE)) begin
        done_cnt_d = done_cnt_q + 1'b1;
        if (done_cnt_q + 1'b1 == n_q) begin
          tile_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
    end

    wr_ready_d = (state_d == ST_FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_LINEAR;
      rows_q      <= CNT_W'(1);
      stride_q    <= CNT_W'(1);
      n_q         <= '0;
      overflow_q  <= 1'b0;
      wr_cnt_q    <= '0;
      addr_q      <= '0;
      row_idx_q   <= '0;
      col_base_q  <= '0;
      rd_ptr_q    <= '0;
      done_cnt_q  <= '0;
      ram_valid_q <= 1'b0;
      tile_done_q <= 1'b0;
      wr_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      rows_q      <= rows_d;
      stride_q    <= stride_d;
      n_q         <= n_d;
      overflow_q  <= overflow_d;
      wr_cnt_q    <= wr_cnt_d;
      addr_q      <= addr_d;
      row_idx_q   <= row_idx_d;
      col_base_q  <= col_base_d;
      rd_ptr_q    <= rd_ptr_d;
      done_cnt_q  <= done_cnt_d;
      ram_valid_q <= ram_valid_d;
      tile_done_q <= tile_done_d;
      wr_ready_q  <= wr_ready_d;
    end
  end

  // Simple dual-port RAM, registered read. Read-during-write of the same
  // entry never happens: an entry is read at the earliest one cycle later.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_addr] <= wr_data;
    if (rd_en)   ram_rd_data_q <= mem[rd_ptr_q[AW-1:0]];
  end

  mm_rd_downsizer #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_downsizer (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (start),
    .in_valid  (ram_valid_q),
    .in_ready  (ds_in_ready),
    .in_data   (ram_rd_data_q),
    .pend      (ram_valid_q),
    .room      (ds_room),
    .out_valid (rd_valid),
    .out_ready (rd_ready),
    .out_data  (rd_data),
    .word_done (ds_word_done)
  );

  assign wr_ready  = wr_ready_q;
  assign tile_done = tile_done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_mm_result_reorder_buffer.sv
module tb_mm_result_reorder_buffer;
  import mm_buf_pkg::*;

  localparam int IN_W  = 64;
  localparam int OUT_W = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int R     = IN_W / OUT_W;

  // clock / reset
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             cfg_mode = 1'b0;
  logic [CNT_W-1:0] cfg_rows = '0;
  logic [CNT_W-1:0] cfg_stride = '0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [IN_W-1:0]  wr_data = '0;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic [OUT_W-1:0] rd_data;
  logic             tile_done;
  logic             overflow;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mm_result_reorder_buffer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode),
    .cfg_rows(cfg_rows), .cfg_stride(cfg_stride),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .tile_done(tile_done), .overflow(overflow)
  );

  // scoreboard state
  int               checks = 0;
  int               errors = 0;
  logic [OUT_W-1:0] exp_q[$];
  int               tile_done_seen = 0;
  int               exp_done = 0;
  bit               arm_rv = 0;
  int               first_rv_cyc = -1;
  bit               watch_fill = 0;
  int               fill_rv_viol = 0;
  bit               prev_stall = 0;
  logic [OUT_W-1:0] prev_data = '0;
  int               stalls_seen = 0;
  int               rr_mode = 0;  // 0 always ready, 1 alternate, 2 random, 3 never

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // consumer ready driver
  initial forever begin
    @(posedge clk); #1;
    case (rr_mode)
      0:       rd_ready = 1'b1;
      1:       rd_ready = ~rd_ready;
      2:       rd_ready = 1'($urandom_range(0, 1));
      default: rd_ready = 1'b0;
    endcase
  end

  // monitor: pops the expected queue whenever a beat is taken
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(rd_valid), 64'd1);
        check("stall_data", 64'(rd_data), 64'(prev_data));
      end
      if (tile_done) tile_done_seen++;
      if (arm_rv && rd_valid && first_rv_cyc < 0) first_rv_cyc = cyc;
      if (watch_fill && rd_valid) fill_rv_viol++;
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected got=%0h exp=none", rd_data);
        end else begin
          logic [OUT_W-1:0] e;
          e = exp_q.pop_front();
          check("beat", 64'(rd_data), 64'(e));
        end
      end
      prev_stall = rd_valid && !rd_ready;
      if (prev_stall) stalls_seen++;
      prev_data = rd_data;
    end
  end

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Reference: place word i at (row*stride + col) and read the image back
  // in address order, low slice first.
  task automatic model_tile(input logic mode, input int rows, input int stride,
                            input logic [IN_W-1:0] words[$]);
    logic [IN_W-1:0] img [DEPTH];
    int rr;
    int ss;
    rr = eff(rows);
    ss = eff(stride);
    for (int i = 0; i < words.size(); i++) begin
      int a;
      a = (mode == MODE_STRIDED) ? (i % rr) * ss + i / rr : i;
      img[a] = words[i];
    end
    for (int a = 0; a < words.size(); a++)
      for (int b = 0; b < R; b++) exp_q.push_back(img[a][b*OUT_W +: OUT_W]);
  endtask

  task automatic do_start(input logic mode, input int rows, input int stride);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_mode = mode;
    cfg_rows = CNT_W'(rows);
    cfg_stride = CNT_W'(stride);
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.delete();
    prev_stall = 0;
    first_rv_cyc = -1;
  endtask

  task automatic write_words(input logic [IN_W-1:0] words[$], input int gap_max,
                             output int first_acc, output int last_acc);
    first_acc = -1;
    last_acc = -1;
    foreach (words[i]) begin
      int gap;
      int budget;
      bit ok;
      gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (gap) begin @(posedge clk); #1; end
      wr_valid = 1'b1;
      wr_data = words[i];
      budget = 50;
      ok = 0;
      while (!ok && budget > 0) begin
        @(negedge clk);
        if (wr_ready) ok = 1;
        @(posedge clk); #1;
        budget--;
      end
      wr_valid = 1'b0;
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL wr_timeout got=wr_ready_low exp=accept word=%0d", i);
        return;
      end
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 400;
    while ((exp_q.size() != 0 || tile_done_seen < exp_done) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    repeat (3) begin @(posedge clk); #1; end
    check({name, "_done"}, 64'(tile_done_seen), 64'(exp_done));
    check({name, "_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_idle"}, 64'(wr_ready), 64'd0);
  endtask

  task automatic gen_words(input int n, output logic [IN_W-1:0] words[$]);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back({$urandom, $urandom});
  endtask

  task automatic run_tile(input logic mode, input int rows, input int stride,
                          input int gap_max, input string name);
    logic [IN_W-1:0] words[$];
    int fa;
    int la;
    int n;
    n = (mode == MODE_LINEAR) ? eff(rows) : eff(rows) * eff(stride);
    do_start(mode, rows, stride);
    gen_words(n, words);
    model_tile(mode, rows, stride, words);
    write_words(words, gap_max, fa, la);
    exp_done++;
    wait_drain(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [IN_W-1:0] words[$];
    logic [IN_W-1:0] words1[$];
    int fa;
    int la;
    int cnt;

    // reset
    repeat (3) @(posedge clk);
    #3;
    check("rst_wr_ready", 64'(wr_ready), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_tile_done", 64'(tile_done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_wr_ready", 64'(wr_ready), 64'd0);

    // 1: linear, four words, always ready
    rr_mode = 0;
    do_start(MODE_LINEAR, 4, 0);
    gen_words(4, words1);
    model_tile(MODE_LINEAR, 4, 0, words1);
    arm_rv = 1;
    write_words(words1, 0, fa, la);
    exp_done++;
    wait_drain("lin");
    check("lin_latency", 64'(first_rv_cyc - fa), 64'd2);
    arm_rv = 0;

    // 2: strided 2x3, nothing readable until the tile is complete
    do_start(MODE_STRIDED, 2, 3);
    gen_words(6, words);
    model_tile(MODE_STRIDED, 2, 3, words);
    fill_rv_viol = 0;
    watch_fill = 1;
    arm_rv = 1;
    write_words(words, 1, fa, la);
    watch_fill = 0;
    check("str_rv_during_fill", 64'(fill_rv_viol), 64'd0);
    exp_done++;
    wait_drain("str");
    check("str_latency", 64'(first_rv_cyc - la), 64'd2);
    arm_rv = 0;

    // 3: same linear tile with alternating ready
    rr_mode = 1;
    stalls_seen = 0;
    do_start(MODE_LINEAR, 4, 0);
    model_tile(MODE_LINEAR, 4, 0, words1);
    write_words(words1, 0, fa, la);
    exp_done++;
    wait_drain("alt");
    check("alt_stalls_seen", 64'(stalls_seen > 0), 64'd1);
    rr_mode = 0;

    // 4: overflow then recovery; also N = DEPTH+1 in linear mode
    do_start(MODE_STRIDED, 5, 4);
    check("ovf_set", 64'(overflow), 64'd1);
    cnt = 0;
    repeat (5) begin @(negedge clk); if (wr_ready) cnt++; end
    check("ovf_wr_ready_low", 64'(cnt), 64'd0);
    run_tile(MODE_STRIDED, 2, 2, 0, "ovf_recover");
    check("ovf_cleared", 64'(overflow), 64'd0);
    do_start(MODE_LINEAR, DEPTH + 1, 0);
    check("ovf_lin17", 64'(overflow), 64'd1);

    // 5: start while a beat is stalled in DRAIN
    rr_mode = 3;
    do_start(MODE_LINEAR, 4, 0);
    check("ovf_clr2", 64'(overflow), 64'd0);
    gen_words(4, words);
    model_tile(MODE_LINEAR, 4, 0, words);
    write_words(words, 0, fa, la);
    repeat (4) begin @(posedge clk); #1; end
    check("abort_pre_valid", 64'(rd_valid), 64'd1);
    do_start(MODE_LINEAR, 1, 0);
    check("abort_rv_drop", 64'(rd_valid), 64'd0);
    rr_mode = 0;
    gen_words(1, words);
    model_tile(MODE_LINEAR, 1, 0, words);
    write_words(words, 0, fa, la);
    exp_done++;
    wait_drain("abort_new");

    // 6: asynchronous reset in the middle of a linear fill
    do_start(MODE_LINEAR, 4, 0);
    gen_words(4, words);
    model_tile(MODE_LINEAR, 4, 0, words);
    words.pop_back();
    words.pop_back();
    write_words(words, 0, fa, la);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_wr_ready", 64'(wr_ready), 64'd0);
    check("arst_rd_valid", 64'(rd_valid), 64'd0);
    check("arst_tile_done", 64'(tile_done), 64'd0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    exp_q.delete();
    repeat (3) begin @(posedge clk); #1; end
    check("arst_idle_wr_ready", 64'(wr_ready), 64'd0);
    check("arst_idle_rd_valid", 64'(rd_valid), 64'd0);
    check("arst_no_done", 64'(tile_done_seen), 64'(exp_done));

    // boundaries: full-depth tiles and zero configuration values
    rr_mode = 2;
    run_tile(MODE_LINEAR, DEPTH, 0, 1, "lin_full");
    run_tile(MODE_STRIDED, 4, 4, 1, "str_full");
    run_tile(MODE_STRIDED, 0, 3, 1, "str_rows0");
    run_tile(MODE_LINEAR, 0, 0, 0, "lin_rows0");

    // randomized tiles
    for (int t = 0; t < 8; t++) begin
      logic m;
      int rows;
      int stride;
      m = 1'($urandom_range(0, 1));
      if (m == MODE_LINEAR) begin
        rows = $urandom_range(1, DEPTH);
        stride = 0;
      end else begin
        rows = $urandom_range(1, 4);
        stride = $urandom_range(1, 4);
      end
      rr_mode = $urandom_range(0, 2);
      run_tile(m, rows, stride, 2, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
